// File: rtl/sid_pkg.sv
// Shared constants, sequencer state encoding and the resonance ROM for the
// multi-channel SID state-variable filter.
package sid_pkg;

    // Cutoff scaling: w0 = (FC_K * (fc + 1)) >> 12
    localparam int unsigned FC_K = 82355;

    typedef enum logic [3:0] {
        IDLE, LOAD, MIX, BP, LP, HP, SUM, OUT, DONE
    } sid_state_e;

    // Resonance feedback coefficient, 1024 = unity
    function automatic logic [10:0] divmul(input logic [3:0] r);
        case (r)
            4'd0:    return 11'd1448;
            4'd1:    return 11'd1328;
            4'd2:    return 11'd1218;
            4'd3:    return 11'd1117;
            4'd4:    return 11'd1024;
            4'd5:    return 11'd939;
            4'd6:    return 11'd861;
            4'd7:    return 11'd790;
            4'd8:    return 11'd724;
            4'd9:    return 11'd664;
            4'd10:   return 11'd609;
            4'd11:   return 11'd558;
            4'd12:   return 11'd512;
            4'd13:   return 11'd470;
            4'd14:   return 11'd431;
            default: return 11'd395;
        endcase
    endfunction

endpackage

// File: rtl/sid_svf_core.sv
// Combinational filter datapath for the channel currently selected by the
// sequencer. Picks the shared-multiplier operands for the active step and
// forms the saturated next-state values from the returned product.
module sid_svf_core
    import sid_pkg::*;
#(
    parameter int SW = 18,
    parameter int MW = 18 + SW
)(
    input  sid_state_e              state,
    input  logic [10:0]             fc,
    input  logic [3:0]              res,
    input  logic [2:0]              mode,     // {hp, bp, lp}
    input  logic [17:0]             w0,
    input  logic [10:0]             q,
    input  logic signed [SW-1:0]    vbp,
    input  logic signed [SW-1:0]    vlp,
    input  logic signed [SW-1:0]    vhp,
    input  logic signed [SW+1:0]    vi,
    input  logic signed [MW-1:0]    mul_p,
    output logic signed [17:0]      mul_a,
    output logic signed [SW-1:0]    mul_b,
    output logic [17:0]             w0_nxt,
    output logic [10:0]             q_nxt,
    output logic signed [SW-1:0]    vbp_nxt,
    output logic signed [SW-1:0]    vlp_nxt,
    output logic signed [SW-1:0]    vhp_nxt,
    output logic signed [SW+1:0]    vf_nxt
);

    // Headroom for sums of a shifted product, two states and the routed mix
    localparam int IW = SW + 6;
    localparam logic signed [IW-1:0] SMAX = IW'(2**(SW-1) - 1);
    localparam logic signed [IW-1:0] SMIN = ~SMAX;

    function automatic logic signed [SW-1:0] sat(input logic signed [IW-1:0] x);
        if (x > SMAX)      return SMAX[SW-1:0];
        else if (x < SMIN) return SMIN[SW-1:0];
        else               return x[SW-1:0];
    endfunction

    logic [29:0]             fc_prod;
    logic signed [MW-1:0]    p19, p10;
    logic signed [SW+1:0]    th, tb, tl;

    // Operand select: w0 for the two integrators, q for the HP feedback
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            BP:      begin mul_a = $signed(w0); mul_b = vhp; end
            LP:      begin mul_a = $signed(w0); mul_b = vbp; end
            HP:      begin mul_a = $signed({7'd0, q}); mul_b = vbp; end
            default: ;
        endcase
    end

    // Next-state values; the sequencer only commits the one for its step
    always_comb begin
        fc_prod = 30'(FC_K) * (30'(fc) + 30'd1);
        w0_nxt  = fc_prod[29:12];
        q_nxt   = divmul(res);
        p19     = mul_p >>> 19;
        p10     = mul_p >>> 10;
        vbp_nxt = sat(IW'(vbp) - IW'(p19));
        vlp_nxt = sat(IW'(vlp) - IW'(p19));
        vhp_nxt = sat(IW'(p10) - IW'(vlp) - IW'(vi));
        th = '0;
        tb = '0;
        tl = '0;
        if (mode[2]) th = (SW+2)'(vhp);
        if (mode[1]) tb = (SW+2)'(vbp);
        if (mode[0]) tl = (SW+2)'(vlp);
        vf_nxt = th + tb + tl;
    end

endmodule

// File: rtl/sid_svf_multi.sv
// Time-multiplexed SID filter for NCH channels of NV voices each. One
// sequencer walks every channel through LOAD, MIX, BP, LP, HP, SUM, OUT and
// publishes all channel outputs together in DONE.
module sid_svf_multi
    import sid_pkg::*;
#(
    parameter int NCH = 2,
    parameter int NV  = 3,
    parameter int VW  = 12,
    parameter int OW  = 18
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_valid,
    input  logic [NCH*11-1:0]      fc,
    input  logic [NCH*8-1:0]       res_filt,
    input  logic [NCH*8-1:0]       mode_vol,
    input  logic [NCH*NV*VW-1:0]   voices,
    input  logic [NCH*VW-1:0]      ext_in,
    input  logic                   extfilter_en,
    output logic [NCH*OW-1:0]      sound,
    output logic                   sound_valid,
    output logic                   busy,
    output logic                   overrun
);

    localparam int SW = VW + 6;
    localparam int MW = 18 + SW;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int XW = $clog2(NV + 1);
    localparam int PW = SW + 9;
    localparam logic signed [PW-1:0] OMAX = PW'(2**(OW-1) - 1);
    localparam logic signed [PW-1:0] OMIN = ~OMAX;

    sid_state_e state, state_nxt;
    logic [CW-1:0] ch;
    logic [XW-1:0] mi;

    // Captured sample
    logic [NCH-1:0][10:0]            fc_q;
    logic [NCH-1:0][7:0]             res_q, mv_q;
    logic [NCH-1:0][NV-1:0][VW-1:0]  voices_q;
    logic [NCH-1:0][VW-1:0]          ext_q;
    logic                            ext_en_q;

    // Per-channel integrator state and per-pass working registers
    logic [NCH-1:0][SW-1:0]  vbp_r, vlp_r, vhp_r;
    logic [17:0]             w0_r;
    logic [10:0]             q_r;
    logic signed [SW+1:0]    vi_r, vnf_r, vf_r;
    logic [NCH-1:0][OW-1:0]  stage_r, sound_r;

    // Core hookup and shared multiplier
    logic signed [17:0]      mul_a;
    logic signed [SW-1:0]    mul_b;
    logic signed [MW-1:0]    mul_p;
    logic [17:0]             w0_nxt;
    logic [10:0]             q_nxt;
    logic signed [SW-1:0]    vbp_nxt, vlp_nxt, vhp_nxt;
    logic signed [SW+1:0]    vf_nxt;

    logic [VW-1:0]           mix_in;
    logic                    routed, drop;
    logic signed [SW+1:0]    mix_x4;
    logic signed [SW+3:0]    m;
    logic signed [PW-1:0]    prod, scaled;
    logic [OW-1:0]           res_out;

    assign mul_p       = mul_a * mul_b;
    assign sound       = sound_r;
    assign busy        = (state != IDLE);
    assign sound_valid = (state == DONE);
    assign overrun     = input_valid && busy;

    sid_svf_core #(.SW(SW), .MW(MW)) u_core (
        .state   (state),
        .fc      (fc_q[ch]),
        .res     (res_q[ch][7:4]),
        .mode    (mv_q[ch][6:4]),
        .w0      (w0_r),
        .q       (q_r),
        .vbp     ($signed(vbp_r[ch])),
        .vlp     ($signed(vlp_r[ch])),
        .vhp     ($signed(vhp_r[ch])),
        .vi      (vi_r),
        .mul_p   (mul_p),
        .mul_a   (mul_a),
        .mul_b   (mul_b),
        .w0_nxt  (w0_nxt),
        .q_nxt   (q_nxt),
        .vbp_nxt (vbp_nxt),
        .vlp_nxt (vlp_nxt),
        .vhp_nxt (vhp_nxt),
        .vf_nxt  (vf_nxt)
    );

    // Select the input for this MIX step and its routing; voices first, then ext
    always_comb begin
        mix_in = ext_q[ch];
        routed = res_q[ch][NV];
        drop   = 1'b0;
        for (int v = 0; v < NV; v++) begin
            if (mi == XW'(v)) begin
                mix_in = voices_q[ch][v];
                routed = res_q[ch][v];
                drop   = (v == 2) && !res_q[ch][v] && mv_q[ch][7];
            end
        end
        mix_x4 = (SW+2)'($signed(mix_in)) <<< 2;
    end

    // Output mix and volume; the mix is wider than 18 bits so the 4-bit
    // volume gets its own small multiplier
    always_comb begin
        if (ext_en_q) m = (SW+4)'(vnf_r) - (SW+4)'(vf_r);
        else          m = (SW+4)'(vnf_r) + (SW+4)'(vi_r);
        prod   = PW'(m) * $signed(PW'(mv_q[ch][3:0]));
        scaled = prod >>> 3;
        if (scaled > OMAX)      res_out = OMAX[OW-1:0];
        else if (scaled < OMIN) res_out = OMIN[OW-1:0];
        else                    res_out = scaled[OW-1:0];
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (input_valid) state_nxt = LOAD;
            LOAD:    state_nxt = MIX;
            MIX:     if (mi == XW'(NV)) state_nxt = BP;
            BP:      state_nxt = LP;
            LP:      state_nxt = HP;
            HP:      state_nxt = SUM;
            SUM:     state_nxt = OUT;
            OUT:     state_nxt = (ch == CW'(NCH-1)) ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers; each step commits exactly one result
    always_ff @(posedge clk) begin
        if (rst) begin
            ch       <= '0;
            mi       <= '0;
            fc_q     <= '0;
            res_q    <= '0;
            mv_q     <= '0;
            voices_q <= '0;
            ext_q    <= '0;
            ext_en_q <= 1'b0;
            vbp_r    <= '0;
            vlp_r    <= '0;
            vhp_r    <= '0;
            w0_r     <= '0;
            q_r      <= '0;
            vi_r     <= '0;
            vnf_r    <= '0;
            vf_r     <= '0;
            stage_r  <= '0;
            sound_r  <= '0;
        end else begin
            case (state)
                IDLE: if (input_valid) begin
                    fc_q     <= fc;
                    res_q    <= res_filt;
                    mv_q     <= mode_vol;
                    voices_q <= voices;
                    ext_q    <= ext_in;
                    ext_en_q <= extfilter_en;
                    ch       <= '0;
                end
                LOAD: begin
                    w0_r  <= w0_nxt;
                    q_r   <= q_nxt;
                    vi_r  <= '0;
                    vnf_r <= '0;
                    mi    <= '0;
                end
                MIX: begin
                    if (!drop) begin
                        if (routed) vi_r  <= vi_r + mix_x4;
                        else        vnf_r <= vnf_r + mix_x4;
                    end
                    mi <= mi + 1'b1;
                end
                BP:  vbp_r[ch] <= vbp_nxt;
                LP:  vlp_r[ch] <= vlp_nxt;
                HP:  vhp_r[ch] <= vhp_nxt;
                SUM: vf_r      <= vf_nxt;
                OUT: begin
                    stage_r[ch] <= res_out;
                    // Last channel: publish every channel at once for DONE
                    if (ch == CW'(NCH-1)) begin
                        for (int c = 0; c < NCH; c++)
                            sound_r[c] <= (CW'(c) == ch) ? res_out : stage_r[c];
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sid_svf_multi.sv
// Directed checks for sid_svf_multi: reset state, latency/busy, bypass and
// routed mixes, voice-2 disable, ext input, output saturation (OW=18 and a
// second OW=14 instance), LP DC settling, overrun and mid-sample reset.
module tb_sid_svf_multi;

    localparam int NCH = 2;
    localparam int NV  = 3;
    localparam int VW  = 12;
    localparam int OW  = 18;
    localparam int OWS = 14;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  input_valid = 1'b0;
    logic [NCH*11-1:0]     fc = '0;
    logic [NCH*8-1:0]      res_filt = '0;
    logic [NCH*8-1:0]      mode_vol = '0;
    logic [NCH*NV*VW-1:0]  voices = '0;
    logic [NCH*VW-1:0]     ext_in = '0;
    logic                  extfilter_en = 1'b1;

    logic [NCH*OW-1:0]     sound;
    logic                  sound_valid, busy, overrun;
    logic [NCH*OWS-1:0]    sound_s;
    logic                  sound_valid_s, busy_s, overrun_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sid_svf_multi #(.NCH(NCH), .NV(NV), .VW(VW), .OW(OW)) dut (
        .clk(clk), .rst(rst), .input_valid(input_valid), .fc(fc),
        .res_filt(res_filt), .mode_vol(mode_vol), .voices(voices),
        .ext_in(ext_in), .extfilter_en(extfilter_en), .sound(sound),
        .sound_valid(sound_valid), .busy(busy), .overrun(overrun)
    );

    sid_svf_multi #(.NCH(NCH), .NV(NV), .VW(VW), .OW(OWS)) dut_s (
        .clk(clk), .rst(rst), .input_valid(input_valid), .fc(fc),
        .res_filt(res_filt), .mode_vol(mode_vol), .voices(voices),
        .ext_in(ext_in), .extfilter_en(extfilter_en), .sound(sound_s),
        .sound_valid(sound_valid_s), .busy(busy_s), .overrun(overrun_s)
    );

    function automatic logic [31:0] snd(input int c);
        return 32'(sound[c*OW +: OW]);
    endfunction

    function automatic logic [31:0] snd_s(input int c);
        return 32'(sound_s[c*OWS +: OWS]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    // Issue one sample at cycle 0 and wait for sound_valid; returns the cycle
    // it appeared on (capped) and busy as seen in cycle 1
    task automatic sample(output int lat, output logic b1);
        @(negedge clk); input_valid = 1'b1;
        @(negedge clk); input_valid = 1'b0; lat = 1; b1 = busy;
        while (!sound_valid && lat < 100) begin
            @(negedge clk); lat++;
        end
    endtask

    task automatic set_voice(input int c, input int v, input logic [VW-1:0] x);
        voices[(c*NV+v)*VW +: VW] = x;
    endtask

    initial begin
        int lat;
        logic b1;
        logic seen;
        logic [31:0] v;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_sound0", snd(0), 0);
        chk("rst_sound1", snd(1), 0);
        chk("rst_valid", 32'(sound_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);

        // All-zero sample, vol 15
        mode_vol = {8'h0F, 8'h0F};
        sample(lat, b1);
        chk("zero_busy_c1", 32'(b1), 1);
        chk("zero_latency", lat, 21);
        chk("zero_busy_c21", 32'(busy), 1);
        chk("zero_sound0", snd(0), 0);
        chk("zero_sound1", snd(1), 0);
        @(negedge clk);
        chk("zero_idle_c22", 32'(busy), 0);
        chk("zero_valid_c22", 32'(sound_valid), 0);

        // Unrouted voice0 on ch0: 0x100*4*15>>3 = 0x780
        set_voice(0, 0, 12'h100);
        sample(lat, b1);
        chk("byp_latency", lat, 21);
        chk("byp_ch0", snd(0), 32'h780);
        chk("byp_ch1", snd(1), 0);

        // Voice 2 unrouted with the voice-2 disable bit, then without
        voices = '0;
        set_voice(0, 2, 12'h100);
        mode_vol[7:0] = 8'h8F;
        sample(lat, b1);
        chk("v2off_ch0", snd(0), 0);
        mode_vol[7:0] = 8'h0F;
        sample(lat, b1);
        chk("v2on_ch0", snd(0), 32'h780);

        // ext on ch1, unrouted, vol 8: -256*4*8>>3 = -1024
        voices = '0;
        ext_in[VW +: VW] = 12'hF00;
        mode_vol[15:8] = 8'h08;
        sample(lat, b1);
        chk("ext_ch1", snd(1), 32'h3FC00);
        chk("ext_ch0", snd(0), 0);

        // Routed voice1 on ch0: bypass gives Vnf+Vi, filtered with no modes gives 0
        ext_in = '0;
        mode_vol[15:8] = 8'h0F;
        set_voice(0, 1, 12'h100);
        res_filt[7:0] = 8'h02;
        extfilter_en = 1'b0;
        sample(lat, b1);
        chk("route_bypass_ch0", snd(0), 32'h780);
        extfilter_en = 1'b1;
        sample(lat, b1);
        chk("route_filt_ch0", snd(0), 0);

        // Output saturation: +8188*15>>3 = 15352, -8192*15>>3 = -15360
        voices = '0;
        res_filt = '0;
        set_voice(0, 0, 12'h7FF);
        sample(lat, b1);
        chk("satp_ow14", snd_s(0), 32'h1FFF);
        chk("satp_ow18", snd(0), 32'h3BF8);
        set_voice(0, 0, 12'h800);
        sample(lat, b1);
        chk("satn_ow14", snd_s(0), 32'h2000);
        chk("satn_ow18", snd(0), 32'h3C400);

        // LP DC settling on ch1: Vlp -> -Vi = -4096, out 4096*15>>3 = 0x1E00.
        // Truncating integrator updates leave a small dead band around that
        // point, hence the window rather than an exact value.
        set_voice(1, 0, 12'h400);
        res_filt[15:8] = 8'h01;
        mode_vol[15:8] = 8'h1F;
        fc[11 +: 11] = 11'h7FF;
        for (int i = 0; i < 1000; i++) sample(lat, b1);
        v = snd(1);
        chk("lp_dc_in_band", 32'((v >= 32'h1E00 - 32) && (v <= 32'h1E00 + 32)), 1);
        chk("lp_ch0_unchanged", snd(0), 32'h3C400);
        chk("lp_latency", lat, 21);

        // input_valid while busy at cycle 5
        @(negedge clk); input_valid = 1'b1;
        @(negedge clk); input_valid = 1'b0;
        repeat (4) @(negedge clk);
        input_valid = 1'b1;
        #1;
        chk("ovr_c5", 32'(overrun), 1);
        @(negedge clk); input_valid = 1'b0;
        #1;
        chk("ovr_c6", 32'(overrun), 0);
        lat = 6;
        while (!sound_valid && lat < 100) begin
            @(negedge clk); lat++;
        end
        chk("ovr_latency", lat, 21);

        // Reset at cycle 10 aborts the sample
        @(negedge clk); input_valid = 1'b1;
        @(negedge clk); input_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (sound_valid) seen = 1'b1;
        end
        chk("rst_mid_no_valid", 32'(seen), 0);
        chk("rst_mid_sound0", snd(0), 0);
        chk("rst_mid_sound1", snd(1), 0);

        // Recovery after reset
        voices = '0;
        res_filt = '0;
        mode_vol = {8'h0F, 8'h0F};
        fc = '0;
        set_voice(0, 0, 12'h100);
        sample(lat, b1);
        chk("post_rst_latency", lat, 21);
        chk("post_rst_ch0", snd(0), 32'h780);
        chk("post_rst_ch1", snd(1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
